vending_machine_stocked: RTL and testbench
==========================================

Name: vending_machine_stocked

Overview:
- Parametrised successor to the vending controller. Item count, coin set, prices and widths are parameters.
- Adds per-item stock tracking, an inactivity timeout with automatic refund, and a registered change-return FSM.
- Change is returned as one coin per cycle, largest denomination first.
- Top-level block. It has no submodule dependencies beyond the team's definitions header.

Parameters:
- NUM_ITEMS, 4, number of items.
- NUM_COINS, 3, number of coin denominations.
- TOTAL_BITS, 31, width of the balance and price arithmetic.
- COIN_VALUES, {1000,500,100}, packed NUM_COINS x TOTAL_BITS. Index 0 is the smallest coin. Values strictly increase with index.
- ITEM_PRICES, {2000,1000,500,400}, packed NUM_ITEMS x TOTAL_BITS. Every price is a multiple of COIN_VALUES[0].
- STOCK_BITS, 4, width of each stock counter.
- STOCK_INIT, 4, stock loaded into every item at reset.
- MAX_BALANCE, 5000, balance ceiling.
- TIMEOUT, 100, idle cycles in ACTIVE before an automatic refund.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_input_coin  in  NUM_COINS  coins inserted this cycle; multiple bits allowed.
- i_select_item  in  NUM_ITEMS  item request bits.
- i_trigger_return  in  1  change-return request.
- o_available_item  out  NUM_ITEMS  combinational from registers: balance >= price AND stock != 0.
- o_output_item  out  NUM_ITEMS  registered one-hot dispense pulse.
- o_return_coin  out  NUM_COINS  registered coin-return pulses.
- o_balance  out  TOTAL_BITS  current balance register.
- o_busy  out  1  high while in RETURN.

Interface fixed fact: one clock; reset is synchronous and active-high.

Behaviour:
Reset:
- balance = 0, state = IDLE, timeout counter = 0, all stock = STOCK_INIT.
- o_output_item = 0, o_return_coin = 0, o_busy = 0.
- Reset asserted mid-RETURN abandons the refund; the balance is lost.

FSM states:
- IDLE: balance == 0.
- ACTIVE: balance > 0.
- RETURN: refunding.

IDLE/ACTIVE, each cycle, with b = balance at the start of the cycle:
- Coin sum: C = sum of COIN_VALUES[k] over the asserted i_input_coin bits.
- Coin acceptance: if b + C - P > MAX_BALANCE, all coins this cycle are rejected. Next cycle o_return_coin equals i_input_coin (echo) and C is treated as 0.
- Purchase: the winner is the lowest index i with i_select_item[i] and o_available_item[i] set. Availability is evaluated on b, not b + C.
  - Winner exists: P = price[i], stock[i] decrements, o_output_item = one-hot(i) next cycle.
  - No winner: P = 0. Unavailable selections are ignored without error.
- At most one item is dispensed per cycle.
- balance_next = b + C - P. All arithmetic is TOTAL_BITS unsigned; no wrap is possible because of the ceiling check and the availability rule.
- State after the update: IDLE if balance_next == 0, otherwise ACTIVE.
- Timeout counter:
  - Clears on any coin, select or state change.
  - Otherwise increments while ACTIVE.
  - At TIMEOUT-1, the next state is RETURN.
- i_trigger_return with balance_next > 0: coins and purchase in the same cycle are still applied, then the next state is RETURN.
- i_trigger_return with balance_next == 0: ignored.

RETURN:
- Each cycle, o_return_coin = one-hot of the largest k with COIN_VALUES[k] <= balance, and that value is subtracted from balance.
- When balance reaches 0, go to IDLE and deassert o_busy.
- Inputs during RETURN:
  - Coins are echoed back on o_return_coin, ORed with the change coin of that cycle.
  - Selects and triggers are ignored.
- o_available_item is forced to 0 while in RETURN.

Stock:
- A counter at 0 blocks availability permanently until reset.
- Counters never underflow.

Optional Feature:
- Macro: VM_SALES_AUDIT_EN.
- Defined:
  - Adds output o_sales_total [TOTAL_BITS-1:0].
  - Registered; accumulates the price of every dispensed item.
  - Saturates at all-ones.
  - Cleared only by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, insert the 500 coin, select item 0 (400) -> o_output_item = 0001 one cycle later, balance 100, stock[0] = 3.
2. Insert 1000 + 500 in the same cycle, then trigger return -> o_balance 1500; return pulses 1000, then 500 on consecutive cycles; o_busy high for 2 cycles, then IDLE.
3. Balance 4500, insert 1000 -> echoed on o_return_coin[2] next cycle; balance stays 4500.
4. Purchase item 1 five times with sufficient credit -> the fifth is not dispensed; o_available_item[1] = 0 while stock[1] = 0.
5. Insert 100, then wait TIMEOUT cycles with no input -> automatic refund of 100 at cycle TIMEOUT+1; state returns to IDLE.
6. Select items 0 and 2 together with balance 1000 -> only item 0 is dispensed; balance 600. With VM_SALES_AUDIT_EN defined, o_sales_total = 400.

Source files
------------

// File: rtl/vending_machine_stocked.sv
// vending_machine_stocked: parametrised vending controller with stock, idle-timeout refund and coin-by-coin change return.
// Define VM_SALES_AUDIT_EN to add the saturating o_sales_total accumulator.
module vending_machine_stocked #(
    parameter int NUM_ITEMS = 4,
    parameter int NUM_COINS = 3,
    parameter int TOTAL_BITS = 31,
    parameter logic [NUM_COINS*TOTAL_BITS-1:0] COIN_VALUES = {31'd1000, 31'd500, 31'd100},
    parameter logic [NUM_ITEMS*TOTAL_BITS-1:0] ITEM_PRICES = {31'd2000, 31'd1000, 31'd500, 31'd400},
    parameter int STOCK_BITS = 4,
    parameter int STOCK_INIT = 4,
    parameter int MAX_BALANCE = 5000,
    parameter int TIMEOUT = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic [NUM_ITEMS-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    output logic [NUM_ITEMS-1:0]  o_available_item,
    output logic [NUM_ITEMS-1:0]  o_output_item,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic [TOTAL_BITS-1:0] o_balance,
    output logic                  o_busy
`ifdef VM_SALES_AUDIT_EN
    ,
    output logic [TOTAL_BITS-1:0] o_sales_total
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RETURN} state_t;

    localparam int EW = TOTAL_BITS + $clog2(NUM_COINS + 2);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    function automatic logic [TOTAL_BITS-1:0] coin_val(input int k);
        return COIN_VALUES[k*TOTAL_BITS +: TOTAL_BITS];
    endfunction

    function automatic logic [TOTAL_BITS-1:0] price_of(input int i);
        return ITEM_PRICES[i*TOTAL_BITS +: TOTAL_BITS];
    endfunction

    state_t                  state_q, state_d;
    logic [TOTAL_BITS-1:0]   bal_q, bal_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_ITEMS-1:0]    item_q, item_d;
    logic [NUM_COINS-1:0]    ret_q, ret_d;
    logic [STOCK_BITS-1:0]   stock_q [NUM_ITEMS];
    logic [STOCK_BITS-1:0]   stock_d [NUM_ITEMS];
    logic [EW-1:0]           coin_sum, sum_ext;
    logic [TOTAL_BITS-1:0]   price, chg_val;
    logic [NUM_COINS-1:0]    chg_hot;
    logic                    found, activity;

    always_comb begin
        o_available_item = '0;
        for (int i = 0; i < NUM_ITEMS; i++)
            o_available_item[i] = (state_q != S_RETURN) && (bal_q >= price_of(i)) && (stock_q[i] != '0);
    end

    always_comb begin
        state_d = state_q;
        bal_d = bal_q;
        cnt_d = cnt_q;
        item_d = '0;
        ret_d = '0;
        stock_d = stock_q;
        coin_sum = '0;
        sum_ext = '0;
        price = '0;
        chg_val = '0;
        chg_hot = '0;
        found = 1'b0;
        activity = (|i_input_coin) || (|i_select_item);
        for (int k = 0; k < NUM_COINS; k++)
            if (i_input_coin[k]) coin_sum = coin_sum + EW'(coin_val(k));
        // Coins ascend in value, so the last fitting coin is the largest one.
        for (int k = 0; k < NUM_COINS; k++)
            if (coin_val(k) <= bal_q) begin
                chg_val = coin_val(k);
                chg_hot = NUM_COINS'(1) << k;
            end
        if (state_q == S_RETURN) begin
            ret_d = i_input_coin | chg_hot;
            bal_d = (chg_hot == '0) ? '0 : bal_q - chg_val;
            state_d = (bal_d == '0) ? S_IDLE : S_RETURN;
            cnt_d = '0;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++)
                if (!found && i_select_item[i] && o_available_item[i]) begin
                    found = 1'b1;
                    price = price_of(i);
                    item_d[i] = 1'b1;
                    stock_d[i] = stock_q[i] - 1'b1;
                end
            sum_ext = EW'(bal_q) + coin_sum - EW'(price);
            if (sum_ext > EW'(MAX_BALANCE)) begin
                ret_d = i_input_coin;
                bal_d = bal_q - price;
            end else begin
                bal_d = sum_ext[TOTAL_BITS-1:0];
            end
            state_d = (bal_d == '0) ? S_IDLE :
                      (i_trigger_return || (state_q == S_ACTIVE && !activity && cnt_q == CNT_W'(TIMEOUT - 1))) ? S_RETURN :
                      S_ACTIVE;
            cnt_d = (activity || state_d != state_q) ? '0 : (state_q == S_ACTIVE) ? cnt_q + 1'b1 : cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bal_q <= '0;
            cnt_q <= '0;
            item_q <= '0;
            ret_q <= '0;
            stock_q <= '{default: STOCK_BITS'(STOCK_INIT)};
        end else begin
            state_q <= state_d;
            bal_q <= bal_d;
            cnt_q <= cnt_d;
            item_q <= item_d;
            ret_q <= ret_d;
            stock_q <= stock_d;
        end
    end

`ifdef VM_SALES_AUDIT_EN
    logic [TOTAL_BITS-1:0] sales_q, sales_d, sales_sum;
    logic                  sales_c;

    always_comb begin
        {sales_c, sales_sum} = {1'b0, sales_q} + {1'b0, price};
        sales_d = sales_c ? '1 : sales_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) sales_q <= '0;
        else sales_q <= sales_d;
    end

    assign o_sales_total = sales_q;
`endif

    assign o_output_item = item_q;
    assign o_return_coin = ret_q;
    assign o_balance = bal_q;
    assign o_busy = (state_q == S_RETURN);

endmodule

// File: tb/tb_vending_machine_stocked.sv
// tb_vending_machine_stocked: directed vectors against hand-computed expectations for vending_machine_stocked.
module tb_vending_machine_stocked;

    localparam int TIMEOUT = 100;

    logic        clk;
    logic        reset;
    logic [2:0]  i_input_coin;
    logic [3:0]  i_select_item;
    logic        i_trigger_return;
    logic [3:0]  o_available_item;
    logic [3:0]  o_output_item;
    logic [2:0]  o_return_coin;
    logic [30:0] o_balance;
    logic        o_busy;
`ifdef VM_SALES_AUDIT_EN
    logic [30:0] o_sales_total;
`endif

    int total = 0;
    int bad = 0;

    vending_machine_stocked dut (
        .clk(clk),
        .reset(reset),
        .i_input_coin(i_input_coin),
        .i_select_item(i_select_item),
        .i_trigger_return(i_trigger_return),
        .o_available_item(o_available_item),
        .o_output_item(o_output_item),
        .o_return_coin(o_return_coin),
        .o_balance(o_balance),
        .o_busy(o_busy)
`ifdef VM_SALES_AUDIT_EN
        ,
        .o_sales_total(o_sales_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [2:0] c, input logic [3:0] s, input logic t);
        i_input_coin = c;
        i_select_item = s;
        i_trigger_return = t;
        @(posedge clk);
        #1;
        i_input_coin = '0;
        i_select_item = '0;
        i_trigger_return = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3'b000, 4'b0000, 1'b0);
        tick(3'b000, 4'b0000, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        i_input_coin = '0;
        i_select_item = '0;
        i_trigger_return = 1'b0;

        do_reset();
        check("rst_balance", o_balance, 0);
        check("rst_output_item", o_output_item, 0);
        check("rst_return_coin", o_return_coin, 0);
        check("rst_busy", o_busy, 0);
        check("rst_avail", o_available_item, 0);

        tick(3'b010, 4'b0000, 1'b0);
        check("t1_bal500", o_balance, 500);
        check("t1_avail500", o_available_item, 4'b0011);
        tick(3'b000, 4'b0001, 1'b0);
        check("t1_dispense", o_output_item, 4'b0001);
        check("t1_bal100", o_balance, 100);
        check("t1_avail100", o_available_item, 4'b0000);
        tick(3'b000, 4'b0000, 1'b0);
        check("t1_pulse_end", o_output_item, 4'b0000);

        do_reset();
        tick(3'b110, 4'b0000, 1'b0);
        check("t2_bal1500", o_balance, 1500);
        check("t2_avail1500", o_available_item, 4'b0111);
        tick(3'b000, 4'b0000, 1'b1);
        check("t2_busy_enter", o_busy, 1);
        check("t2_avail_ret", o_available_item, 4'b0000);
        check("t2_ret_none", o_return_coin, 3'b000);
        tick(3'b000, 4'b0000, 1'b0);
        check("t2_ret1000", o_return_coin, 3'b100);
        check("t2_busy2", o_busy, 1);
        check("t2_bal500", o_balance, 500);
        tick(3'b000, 4'b0000, 1'b0);
        check("t2_ret500", o_return_coin, 3'b010);
        check("t2_busy_off", o_busy, 0);
        check("t2_bal0", o_balance, 0);
        tick(3'b000, 4'b0000, 1'b1);
        check("t2_trig_zero_ignored", o_busy, 0);
        check("t2_ret_quiet", o_return_coin, 3'b000);

        do_reset();
        for (int i = 0; i < 3; i++) tick(3'b110, 4'b0000, 1'b0);
        check("t3_bal4500", o_balance, 4500);
        tick(3'b100, 4'b0000, 1'b0);
        check("t3_echo", o_return_coin, 3'b100);
        check("t3_bal_kept", o_balance, 4500);
        tick(3'b010, 4'b0000, 1'b0);
        check("t3_ceiling_exact", o_balance, 5000);
        check("t3_no_echo", o_return_coin, 3'b000);

        do_reset();
        tick(3'b110, 4'b0000, 1'b0);
        tick(3'b110, 4'b0000, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick(3'b000, 4'b0010, 1'b0);
            check($sformatf("t4_item_%0d", k), o_output_item, (k < 5) ? 4'b0010 : 4'b0000);
            check($sformatf("t4_bal_%0d", k), o_balance, 3000 - 500 * ((k < 5) ? k : 4));
        end
        check("t4_avail", o_available_item, 4'b0101);

        do_reset();
        tick(3'b001, 4'b0000, 1'b0);
        n = 0;
        while (n < TIMEOUT + 10) begin
            tick(3'b000, 4'b0000, 1'b0);
            n++;
            if (o_return_coin != 3'b000) break;
        end
        check("t5_timeout_cycles", n, TIMEOUT + 1);
        check("t5_refund_coin", o_return_coin, 3'b001);
        check("t5_bal0", o_balance, 0);
        check("t5_idle", o_busy, 0);

        do_reset();
        tick(3'b100, 4'b0000, 1'b0);
        check("t6_avail1000", o_available_item, 4'b0111);
        tick(3'b000, 4'b0101, 1'b0);
        check("t6_lowest_wins", o_output_item, 4'b0001);
        check("t6_bal600", o_balance, 600);
`ifdef VM_SALES_AUDIT_EN
        check("t6_sales", o_sales_total, 400);
`endif

        do_reset();
        tick(3'b010, 4'b0000, 1'b0);
        tick(3'b000, 4'b0000, 1'b1);
        tick(3'b001, 4'b0001, 1'b1);
        check("t7_echo_or_change", o_return_coin, 3'b011);
        check("t7_no_dispense", o_output_item, 4'b0000);
        check("t7_bal0", o_balance, 0);
        check("t7_idle", o_busy, 0);

        do_reset();
        tick(3'b110, 4'b0000, 1'b0);
        tick(3'b000, 4'b0000, 1'b1);
        reset = 1'b1;
        tick(3'b000, 4'b0000, 1'b0);
        reset = 1'b0;
        check("t8_rst_bal", o_balance, 0);
        check("t8_rst_busy", o_busy, 0);
        check("t8_rst_ret", o_return_coin, 3'b000);

        do_reset();
        tick(3'b001, 4'b0000, 1'b0);
        tick(3'b010, 4'b0001, 1'b0);
        check("t9_avail_on_b", o_output_item, 4'b0000);
        check("t9_bal600", o_balance, 600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
